// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, response LATENCY+1 cycles after request handshake.
// Backpressure: req_ready only in IDLE; rsp_ready low holds the response stable indefinitely.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_be;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          req_hs;
    logic          rsp_hs;
    logic          do_access;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    logic [31:0]   mem [DEPTH_WORDS];

    assign req_hs = bus.req_valid && (state == IDLE);
    assign rsp_hs = bus.rsp_ready && (state == RESP);

    // With LATENCY=0 the access happens on the handshake edge, so it must see the live request.
    assign acc_write = (state == IDLE) ? bus.req_write : cap_write;
    assign acc_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
    assign acc_be    = (state == IDLE) ? bus.req_be    : cap_be;
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_LIM);
    assign acc_idx   = acc_addr[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = RESP;
                    do_access = 1'b1;
                end
            end
            RESP: begin
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (req_hs) begin
                cnt       <= CW'(LATENCY);
                cap_write <= bus.req_write;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                cap_be    <= bus.req_be;
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end

            if (do_access) begin
                err_q   <= acc_err;
                rdata_q <= (!acc_err && !acc_write) ? mem[acc_idx] : 32'h0;
            end else if (rsp_hs) begin
                err_q   <= 1'b0;
                rdata_q <= 32'h0;
            end
        end
    end

    // Array is not reset; gating on reset keeps a request seen during reset from writing.
    always_ff @(posedge clk) begin
        if (reset && do_access && !acc_err && acc_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != IDLE);
endmodule
